layer_conv_sequencer: RTL and testbench
=======================================

# layer_conv_sequencer

Frame sequencer that sits in front of a layer's bank of per-channel 3x3 convolution featuremaps. It accepts a channel-parallel pixel stream from the previous layer with a valid/ready handshake and walks each frame in raster order. It inserts the zero border the 3x3 windows need and drives the bank's single shared `valid_in` strobe. It also counts the bank's result strobes to decide when the frame is finished, giving the layer top a clean start/busy/done control interface.

## Interface
- `DATA_WIDTH`, 32, width of one channel element (fp32).
- `CHANNELS`, 32, input channels carried side by side on one beat.
- `IMG_SIZE`, 104, unpadded frame edge in pixels.

- `Clk`  in  1  clock, rising edge.
- `Rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin one frame; sampled in IDLE only.
- `s_data`  in  CHANNELS*DATA_WIDTH  input pixel; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  the sequencer accepts `s_data` this cycle.
- `conv_data`  out  CHANNELS*DATA_WIDTH  element sent to the featuremap bank `data_in`.
- `conv_valid`  out  1  drives the bank `valid_in`.
- `res_valid`  in  1  the bank's `valid_out`, one pulse per output pixel.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  single-cycle pulse at frame end.

## Operation
- Padded edge `P` = IMG_SIZE+2 when padding is compiled in, otherwise IMG_SIZE.
- Counters:
  - `row` and `col` count 0..P-1; `col` wraps to 0 and increments `row`.
  - `res_cnt` counts 0..IMG_SIZE².
  - Counter width is $clog2(P) and $clog2(IMG_SIZE²+1) respectively.
- A padded position is `row` ∈ {0, P-1} or `col` ∈ {0, P-1}. It only exists when padding is enabled.
- States:
  - IDLE: outputs quiet. On `start`, clear `row`, `col` and `res_cnt`, then go to FEED.
  - FEED, padded position: emit zeros with `conv_valid`=1 every cycle. `s_ready`=0, so no input is consumed.
  - FEED, interior position: `s_ready`=1. When `s_valid && s_ready`, register `s_data`, pulse `conv_valid` and advance `col`/`row`. With no handshake, hold position and set `conv_valid`=0.
  - FEED exit: after the element at (P-1, P-1) is emitted, go to DRAIN.
  - DRAIN: `s_ready`=0. Wait for `res_cnt` to reach IMG_SIZE², then go to DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- `res_valid` increments `res_cnt` in FEED and DRAIN only. It is ignored in IDLE and DONE.
- If `res_valid` would push `res_cnt` past IMG_SIZE², the counter saturates.
- `start` while busy is ignored.
- An assertion of `s_valid` in IDLE or DRAIN is held off (`s_ready`=0) and is never dropped.
- Reset mid-frame: all state returns to IDLE immediately. The partial frame is abandoned and no `done` is produced.

## Timing
- Reset values: `s_ready`=0, `conv_valid`=0, `conv_data`=0, `busy`=0, `done`=0.
- `s_ready` is combinational from state and position. It never depends on `s_valid`.
- `conv_data` and `conv_valid` are registered, one cycle after the accepted beat or padded slot.
- `busy` rises the cycle after `start` is sampled and falls in the same cycle `done` is high.
- Padding enabled, no stalls: FEED lasts exactly P² cycles.
- `done` comes 1 cycle after the IMG_SIZE²-th `res_valid` is registered.
- No backpressure from the bank: `conv_valid` is never withheld for a downstream reason.

## Configuration
- `LAYER_SEQ_PAD_EN` defined: one-pixel zero border, P = IMG_SIZE+2, (IMG_SIZE+2)² emits per frame.
- `LAYER_SEQ_PAD_EN` undefined: P = IMG_SIZE, no padded positions, exactly IMG_SIZE² emits. `s_ready`=1 throughout FEED.

## Structure
- Shared package `layer_seq_pkg` holds:
  - the state enum `seq_state_t` (IDLE, FEED, DRAIN, DONE);
  - the `DATA_WIDTH` default;
  - a function `is_pad(row, col, P)`.
- One sub-module, `raster_counter`: a parameterised row/col counter with an advance enable, wrap, and a last-position flag, reusable by other layer sequencers.

## Test plan
- Padding on, IMG_SIZE=4, `s_valid` held 1, `start` pulse:
  - 36 `conv_valid` pulses, 16 handshakes;
  - first 7 and last 7 emits are zero;
  - with a `res_valid` model after 5 cycles, `done` appears once.
- Random `s_valid` gaps (about 30% idle), IMG_SIZE=4: `conv_data` matches the input order exactly, with zeros at the 20 border slots and no duplicated or lost beats.
- Padding off, IMG_SIZE=4: exactly 16 `conv_valid` pulses, `s_ready`=1 for all of FEED, `done` after the 16th `res_valid`.
- `start` pulsed during FEED and DRAIN: no effect. Extra `res_valid` pulses in IDLE: `res_cnt` unchanged, no spurious `done`.
- `Rst` low at emit 10 of a frame: all outputs go to 0 asynchronously. After release, a new `start` runs a full correct frame.
- Hold `res_valid` low in DRAIN for 50 cycles: `busy` stays 1, no `done`, `s_ready`=0. Releasing 16 pulses then produces `done`.

Source files
------------

// File: rtl/layer_seq_pkg.sv
// Shared state type and helpers for the layer input sequencers.
// The one-pixel zero border is compiled in when LAYER_SEQ_PAD_EN is defined.
package layer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } seq_state_t;

  localparam int SEQ_DATA_WIDTH = 32;

`ifdef LAYER_SEQ_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int PAD_BORDER = PAD_EN ? 2 : 0;

  // Without the border compiled in there are no padded positions at all.
  function automatic logic is_pad(input logic [31:0] row, input logic [31:0] col,
                                  input logic [31:0] p);
    if (!PAD_EN) return 1'b0;
    return (row == 32'd0) || (row == p - 32'd1) || (col == 32'd0) || (col == p - 32'd1);
  endfunction

endpackage

// File: rtl/layer_conv_sequencer_raster.sv
// Row/column raster counter over a SIZE x SIZE grid with clear, advance,
// wrap and a flag marking the final position of the frame.
module raster_counter #(
  parameter int SIZE = 6,
  localparam int W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_advance,
  output logic [W-1:0] o_row,
  output logic [W-1:0] o_col,
  output logic         o_last
);

  localparam logic [W-1:0] LAST_IDX = W'(SIZE - 1);

  logic [W-1:0] r_row;
  logic [W-1:0] r_col;
  logic         w_col_wrap;
  logic         w_row_wrap;

  assign w_col_wrap = (r_col == LAST_IDX);
  assign w_row_wrap = (r_row == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_wrap ? '0 : r_row + W'(1);
      end else begin
        r_col <= r_col + W'(1);
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = w_col_wrap && w_row_wrap;

endmodule

// File: rtl/layer_conv_sequencer.sv
// Frame sequencer feeding a bank of 3x3 featuremaps: raster walk, zero border
// (LAYER_SEQ_PAD_EN), shared valid strobe and result counting for done.
module layer_conv_sequencer
  import layer_seq_pkg::*;
#(
  parameter int DATA_WIDTH = SEQ_DATA_WIDTH,
  parameter int CHANNELS   = 32,
  parameter int IMG_SIZE   = 104
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           start,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] conv_data,
  output logic                           conv_valid,
  input  logic                           res_valid,
  output logic                           busy,
  output logic                           done
);

  localparam int P    = IMG_SIZE + PAD_BORDER;
  localparam int PW   = (P > 1) ? $clog2(P) : 1;
  localparam int NPIX = IMG_SIZE * IMG_SIZE;
  localparam int RW   = $clog2(NPIX + 1);
  localparam logic [RW-1:0] RES_LAST = RW'(NPIX);

  seq_state_t r_state;
  seq_state_t w_next;

  logic [PW-1:0]                  w_row;
  logic [PW-1:0]                  w_col;
  logic                           w_last;
  logic                           w_pad;
  logic                           w_emit;
  logic                           w_clear;
  logic                           w_count_en;
  logic [RW-1:0]                  r_res_cnt;
  logic [CHANNELS*DATA_WIDTH-1:0] r_conv_data;
  logic                           r_conv_valid;

  raster_counter #(
    .SIZE(P)
  ) u_raster (
    .i_clk    (Clk),
    .i_rst_n  (Rst),
    .i_clear  (w_clear),
    .i_advance(w_emit),
    .o_row    (w_row),
    .o_col    (w_col),
    .o_last   (w_last)
  );

  assign w_pad = is_pad(32'(w_row), 32'(w_col), 32'(P));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Border slots emit on their own every cycle; interior slots wait for a beat.
  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_emit     = 1'b0;
    w_count_en = 1'b0;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next  = FEED;
          w_clear = 1'b1;
        end
      end
      FEED: begin
        busy       = 1'b1;
        w_count_en = 1'b1;
        s_ready    = !w_pad;
        w_emit     = w_pad || s_valid;
        if (w_emit && w_last) w_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        w_count_en = 1'b1;
        if (r_res_cnt == RES_LAST) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_res_cnt <= '0;
    end else if (w_clear) begin
      r_res_cnt <= '0;
    end else if (w_count_en && res_valid && (r_res_cnt != RES_LAST)) begin
      r_res_cnt <= r_res_cnt + RW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_conv_valid <= 1'b0;
      r_conv_data  <= '0;
    end else begin
      r_conv_valid <= w_emit;
      if (w_emit) r_conv_data <= w_pad ? '0 : s_data;
    end
  end

  assign conv_valid = r_conv_valid;
  assign conv_data  = r_conv_data;

endmodule

// File: tb/tb_layer_conv_sequencer.sv
// Randomised self-checking bench for layer_conv_sequencer with a frame-level
// reference model; follows the LAYER_SEQ_PAD_EN build setting of the design.
module tb_layer_conv_sequencer;

  localparam int DW    = 8;
  localparam int CH    = 2;
  localparam int IMG   = 4;
  localparam int NPIX  = IMG * IMG;
  localparam int DATAW = DW * CH;
`ifdef LAYER_SEQ_PAD_EN
  localparam int P = IMG + 2;
`else
  localparam int P = IMG;
`endif
  localparam int EMITS = P * P;

  localparam int PH_IDLE  = 0;
  localparam int PH_FEED  = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             start = 1'b0;
  logic [DATAW-1:0] s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DATAW-1:0] conv_data;
  logic             conv_valid;
  logic             res_valid = 1'b0;
  logic             busy;
  logic             done;

  layer_conv_sequencer #(
    .DATA_WIDTH(DW),
    .CHANNELS  (CH),
    .IMG_SIZE  (IMG)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .start     (start),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .conv_data (conv_data),
    .conv_valid(conv_valid),
    .res_valid (res_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame phase, raster position, result count, last emit.
  int               mPhase = PH_IDLE;
  int               mPos = 0;
  int               mRes = 0;
  logic             mValid = 1'b0;
  logic [DATAW-1:0] mData = '0;
  logic [4:0]       resPipe = '0;

  int validPct = 100;
  int resMode = 0;
  int dutEmits = 0;
  int dutDones = 0;
  int dutHs = 0;
  int readyGaps = 0;
  logic [DATAW-1:0] emitLog [64];

  function automatic bit padAt(input int pos);
    int r;
    int c;
    if (P == IMG) return 1'b0;
    r = pos / P;
    c = pos % P;
    return (r == 0) || (r == P - 1) || (c == 0) || (c == P - 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPhase  = PH_IDLE;
    mPos    = 0;
    mRes    = 0;
    mValid  = 1'b0;
    mData   = '0;
    resPipe = '0;
  endtask

  // One clock of the frame rules; res_valid counts against the phase before the edge.
  task automatic modelStep();
    int ph;
    bit pad;
    bit emit;
    ph      = mPhase;
    emit    = 1'b0;
    resPipe = {resPipe[3:0], 1'b0};
    case (ph)
      PH_IDLE: begin
        if (start) begin
          mPhase = PH_FEED;
          mPos   = 0;
          mRes   = 0;
        end
      end
      PH_FEED: begin
        pad = padAt(mPos);
        if (pad || s_valid) begin
          emit  = 1'b1;
          mData = pad ? '0 : s_data;
          if (!pad) resPipe[0] = 1'b1;
          mPos++;
          if (mPos == EMITS) mPhase = PH_DRAIN;
        end
      end
      PH_DRAIN: begin
        if (mRes == NPIX) mPhase = PH_DONE;
      end
      default: mPhase = PH_IDLE;
    endcase
    if ((ph == PH_FEED || ph == PH_DRAIN) && res_valid && mRes < NPIX) mRes++;
    mValid = emit;
  endtask

  initial begin
    forever begin
      @(posedge Clk or negedge Rst);
      if (!Rst) modelReset();
      else modelStep();
    end
  end

  // Input driver: fresh random beat every cycle, res_valid by selected mode.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      s_valid = ($urandom_range(99) < validPct);
      s_data  = DATAW'($urandom);
      case (resMode)
        1:       res_valid = resPipe[4];
        2:       res_valid = ($urandom_range(99) < 30);
        3:       res_valid = 1'b1;
        default: res_valid = 1'b0;
      endcase
    end
  end

  // Per-cycle compare against the model, plus DUT-side event counters.
  initial begin
    forever begin
      @(negedge Clk);
      checkOutput("s_ready", 32'(s_ready), 32'((mPhase == PH_FEED) && !padAt(mPos)));
      checkOutput("conv_valid", 32'(conv_valid), 32'(mValid));
      if (mValid) checkOutput("conv_data", 32'(conv_data), 32'(mData));
      checkOutput("busy", 32'(busy), 32'((mPhase == PH_FEED) || (mPhase == PH_DRAIN)));
      checkOutput("done", 32'(done), 32'(mPhase == PH_DONE));
      if (conv_valid) begin
        if (dutEmits < 64) emitLog[dutEmits] = conv_data;
        dutEmits++;
      end
      if (done) dutDones++;
      if (s_valid && s_ready) dutHs++;
      if (mPhase == PH_FEED && !s_ready) readyGaps++;
    end
  end

  task automatic pulseStart();
    @(posedge Clk);
    #1 start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
  endtask

  task automatic waitPhase(input int ph, input string name);
    int cyc;
    cyc = 0;
    while (mPhase != ph && cyc < 2000) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    checkOutput(name, 32'(cyc < 2000), 32'd1);
  endtask

  task automatic clearCounts();
    dutEmits  = 0;
    dutDones  = 0;
    dutHs     = 0;
    readyGaps = 0;
  endtask

  task automatic applyStimulus(input int vp, input int rm, input bit extraStarts);
    int  cyc;
    bit  drainPulsed;
    validPct = vp;
    resMode  = rm;
    clearCounts();
    pulseStart();
    cyc         = 0;
    drainPulsed = 1'b0;
    while (mPhase != PH_IDLE && cyc < 2000) begin
      @(posedge Clk);
      #1;
      cyc++;
      start = 1'b0;
      if (extraStarts && cyc == 10) start = 1'b1;
      if (extraStarts && mPhase == PH_DRAIN && !drainPulsed) begin
        start       = 1'b1;
        drainPulsed = 1'b1;
      end
    end
    start = 1'b0;
    checkOutput("frame_finishes", 32'(cyc < 2000), 32'd1);
  endtask

  task automatic checkFrameTotals(input string tag);
    int zeros;
    checkOutput({tag, "_emits"}, 32'(dutEmits), 32'(EMITS));
    checkOutput({tag, "_handshakes"}, 32'(dutHs), 32'd16);
    checkOutput({tag, "_done_pulses"}, 32'(dutDones), 32'd1);
`ifdef LAYER_SEQ_PAD_EN
    zeros = 0;
    for (int i = 0; i < 7; i++) begin
      if (emitLog[i] == '0) zeros++;
      if (emitLog[EMITS-1-i] == '0) zeros++;
    end
    checkOutput({tag, "_border_zeros"}, 32'(zeros), 32'd14);
`else
    zeros = readyGaps;
    checkOutput({tag, "_ready_gaps"}, 32'(zeros), 32'd0);
`endif
  endtask

  initial begin
    int cyc;
    #1 Rst = 1'b0;
    #1;
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_conv_valid", 32'(conv_valid), 32'd0);
    checkOutput("rst_conv_data", 32'(conv_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    #10 Rst = 1'b1;

    // Full-rate frame with a bank model answering 5 cycles after each pixel.
    applyStimulus(100, 1, 1'b0);
    checkFrameTotals("full_rate");

    // Input gaps about 30 percent of the time.
    applyStimulus(70, 1, 1'b0);
    checkFrameTotals("gappy");

    // Stray results while idle, then a frame with start pulses in FEED and DRAIN.
    resMode = 3;
    clearCounts();
    repeat (6) @(posedge Clk);
    #1 resMode = 0;
    repeat (3) @(posedge Clk);
    checkOutput("idle_res_no_done", 32'(dutDones), 32'd0);
    applyStimulus(85, 1, 1'b1);
    checkFrameTotals("extra_start");

    // Reset abandoned at the tenth emit.
    validPct = 100;
    resMode  = 1;
    clearCounts();
    pulseStart();
    cyc = 0;
    while (dutEmits < 10 && cyc < 200) begin
      @(negedge Clk);
      #1;
      cyc++;
    end
    checkOutput("reached_emit10", 32'(dutEmits >= 10), 32'd1);
    Rst = 1'b0;
    #1;
    checkOutput("midrst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("midrst_conv_valid", 32'(conv_valid), 32'd0);
    checkOutput("midrst_conv_data", 32'(conv_data), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    repeat (3) @(negedge Clk);
    #1 Rst = 1'b1;
    repeat (4) @(posedge Clk);
    checkOutput("midrst_no_done", 32'(dutDones), 32'd0);
    applyStimulus(75, 1, 1'b0);
    checkFrameTotals("after_reset");

    // Results withheld through a long DRAIN, then released (and over-supplied).
    validPct = 80;
    resMode  = 0;
    clearCounts();
    pulseStart();
    waitPhase(PH_DRAIN, "reach_drain");
    repeat (50) @(posedge Clk);
    #1;
    checkOutput("drain_busy_held", 32'(busy), 32'd1);
    checkOutput("drain_ready_low", 32'(s_ready), 32'd0);
    checkOutput("drain_no_done", 32'(dutDones), 32'd0);
    resMode = 3;
    waitPhase(PH_IDLE, "drain_release_finishes");
    resMode = 0;
    repeat (3) @(posedge Clk);
    checkOutput("drain_done_once", 32'(dutDones), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
